id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage MIPS core, with built-in load-use hazard detection.
- Captures decoded operands, register indices and control bits from ID each cycle.
- Its ID_EX_RS_o/ID_EX_RT_o/ID_EX_regwrite_o outputs feed the EX-stage forwarding unit and operand muxes.
- Inserts bubbles and raises stall_o toward PC and IF/ID when an instruction in ID needs a load result not yet available.

---
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register for the 5-stage MIPS core with
//                built-in load-use hazard detection and bubble insertion.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
  parameter int LOAD_DELAY = 1,   // bubbles per load-use hazard, 1..7
  parameter int DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,           // asynchronous, active-low
  input  logic              mem_stall_i,
  input  logic              flush_i,
  input  logic              IF_ID_valid_i,
  input  logic [4:0]        IF_ID_RS_i,
  input  logic [4:0]        IF_ID_RT_i,
  input  logic [4:0]        IF_ID_RD_i,
  input  logic              IF_ID_uses_rt_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [7:0]        ctrl_i,
  output logic              ID_EX_valid_o,
  output logic [4:0]        ID_EX_RS_o,
  output logic [4:0]        ID_EX_RT_o,
  output logic [4:0]        ID_EX_RD_o,
  output logic [DATA_W-1:0] ID_EX_rs_data_o,
  output logic [DATA_W-1:0] ID_EX_rt_data_o,
  output logic [DATA_W-1:0] ID_EX_imm_o,
  output logic [7:0]        ID_EX_ctrl_o,
  output logic              ID_EX_regwrite_o,
  output logic              stall_o
);

  // Counter value loaded when a new hazard is first seen; the hazard cycle
  // itself is the first bubble, so only LOAD_DELAY-1 more remain.
  localparam logic [2:0] c_RELOAD_CNT = 3'(LOAD_DELAY - 1);

  logic              valid_q,   valid_d;
  logic [4:0]        rs_q,      rs_d;
  logic [4:0]        rt_q,      rt_d;
  logic [4:0]        rd_q,      rd_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [7:0]        ctrl_q,    ctrl_d;
  logic [2:0]        cnt_q,     cnt_d;

  logic w_hazard;
  logic w_cnt_busy;
  logic w_load_bubble;

  // Load-use detection: a valid load in EX whose non-zero destination is read by ID
  always_comb begin
    w_hazard = valid_q && ctrl_q[5] && IF_ID_valid_i && (rt_q != 5'd0) &&
               ((rt_q == IF_ID_RS_i) || (IF_ID_uses_rt_i && (rt_q == IF_ID_RT_i)));
  end

  assign w_cnt_busy = (cnt_q != 3'd0);

  // Stall is combinational so PC and IF/ID freeze in the very cycle the hazard appears
  assign stall_o = (w_hazard && !w_cnt_busy) || w_cnt_busy;

  // Next-state selection: freeze, flush, drain pending bubbles, new hazard, or capture
  always_comb begin
    valid_d       = valid_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    rd_d          = rd_q;
    rs_data_d     = rs_data_q;
    rt_data_d     = rt_data_q;
    imm_d         = imm_q;
    ctrl_d        = ctrl_q;
    cnt_d         = cnt_q;
    w_load_bubble = 1'b0;

    if (!mem_stall_i) begin
      if (flush_i) begin
        w_load_bubble = 1'b1;
        cnt_d         = 3'd0;
      end else if (w_cnt_busy) begin
        w_load_bubble = 1'b1;
        cnt_d         = cnt_q - 3'd1;
      end else if (w_hazard) begin
        w_load_bubble = 1'b1;
        cnt_d         = c_RELOAD_CNT;
      end else begin
        valid_d   = IF_ID_valid_i;
        rs_d      = IF_ID_RS_i;
        rt_d      = IF_ID_RT_i;
        rd_d      = IF_ID_RD_i;
        rs_data_d = rs_data_i;
        rt_data_d = rt_data_i;
        imm_d     = imm_i;
        // An empty ID slot must not carry live control into later stages
        ctrl_d    = IF_ID_valid_i ? ctrl_i : 8'd0;
      end
    end

    // Bubbles clear indices too so the forwarding unit can never match them
    if (w_load_bubble) begin
      valid_d   = 1'b0;
      rs_d      = 5'd0;
      rt_d      = 5'd0;
      rd_d      = 5'd0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      ctrl_d    = 8'd0;
    end
  end

  // Pipeline register and bubble counter, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q   <= 1'b0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= 8'd0;
      cnt_q     <= 3'd0;
    end else begin
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ID_EX_valid_o    = valid_q;
  assign ID_EX_RS_o       = rs_q;
  assign ID_EX_RT_o       = rt_q;
  assign ID_EX_RD_o       = rd_q;
  assign ID_EX_rs_data_o  = rs_data_q;
  assign ID_EX_rt_data_o  = rt_data_q;
  assign ID_EX_imm_o      = imm_q;
  assign ID_EX_ctrl_o     = ctrl_q;
  assign ID_EX_regwrite_o = ctrl_q[7];

endmodule
`default_nettype wire
